// File: rtl/mdu_controller_if.sv
// Request/response bundle between the EX stage and the multi-cycle M-extension unit.
interface mdu_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  START;
    logic [2:0]            FUNCT3;
    logic [DATA_WIDTH-1:0] DATA1;
    logic [DATA_WIDTH-1:0] DATA2;
    logic                  KILL;
    logic                  BUSY;
    logic                  STALL;
    logic                  DONE;
    logic [DATA_WIDTH-1:0] RESULT;

    modport master (
        output START, FUNCT3, DATA1, DATA2, KILL,
        input  BUSY, STALL, DONE, RESULT
    );

    modport slave (
        input  START, FUNCT3, DATA1, DATA2, KILL,
        output BUSY, STALL, DONE, RESULT
    );
endinterface

// File: rtl/mdu_controller.sv
// RV32 M-extension sequencer: shift-add multiply / restoring divide on a shared
// 2*DATA_WIDTH accumulator, with sign correction and divide special-case bypass.
//   state  | meaning
//   IDLE   | waiting for START
//   CALC   | one multiply/divide iteration per cycle
//   FIX    | sign correction and result select
//   DONE   | one-cycle DONE pulse, may accept a new START
module mdu_controller #(
    parameter int DATA_WIDTH = 32
) (
    input logic             CLK,
    input logic             RESET,
    mdu_controller_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST    = CW'(W - 1);
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic [W-1:0]    result_q, result_d;

    logic            accept;
    logic            is_div;
    logic            sgn1, sgn2, s1, s2;
    logic [W-1:0]    mag1, mag2;
    logic            div_zero, ovf, special;
    logic [W-1:0]    special_res;

    logic [W:0]      mul_sum;
    logic [W:0]      div_rs;
    logic            div_ge;
    logic [W-1:0]    div_diff;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix, rem_fix, fix_res;

    logic            busy, done, stall;

    // Operand preparation and special-case detection on the request inputs
    always_comb begin
        is_div = bus.FUNCT3[2];
        sgn1   = 1'b0;
        sgn2   = 1'b0;
        case (bus.FUNCT3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            3'b010:  sgn1 = 1'b1;
            default: ;
        endcase
        s1       = sgn1 & bus.DATA1[W-1];
        s2       = sgn2 & bus.DATA2[W-1];
        mag1     = s1 ? (~bus.DATA1 + 1'b1) : bus.DATA1;
        mag2     = s2 ? (~bus.DATA2 + 1'b1) : bus.DATA2;
        div_zero = is_div && (bus.DATA2 == '0);
        ovf      = is_div && !bus.FUNCT3[0] && (bus.DATA1 == MIN_NEG) && (bus.DATA2 == '1);
        special  = div_zero || ovf;
        if (div_zero) begin
            special_res = bus.FUNCT3[1] ? bus.DATA1 : '1;
        end else begin
            special_res = bus.FUNCT3[1] ? '0 : MIN_NEG;
        end
        accept = bus.START && !bus.KILL && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = special ? S_DONE : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (bus.KILL) begin
                    state_d = S_IDLE;
                end else if (count_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = bus.KILL ? S_IDLE : S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: one accumulator holds {hi, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
        div_rs   = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge   = div_rs >= {1'b0, opnd_q};
        div_diff = div_rs[W-1:0] - opnd_q;

        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
        rem_fix  = rneg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
        case (op_q)
            3'b000:                 fix_res = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase

        count_d  = count_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        if (accept) begin
            count_d = '0;
            op_d    = bus.FUNCT3;
            opnd_d  = is_div ? mag2 : mag1;
            acc_d   = {{W{1'b0}}, (is_div ? mag1 : mag2)};
            neg_d   = s1 ^ s2;
            rneg_d  = s1;
            if (special) begin
                result_d = special_res;
            end
        end else if (state_q == S_CALC) begin
            count_d = count_q + 1'b1;
            if (op_q[2]) begin
                if (div_ge) begin
                    acc_d = {div_diff, acc_q[W-2:0], 1'b1};
                end else begin
                    acc_d = {div_rs[W-1:0], acc_q[W-2:0], 1'b0};
                end
            end else if (acc_q[0]) begin
                acc_d = {mul_sum, acc_q[W-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*W-1:1]};
            end
        end else if ((state_q == S_FIX) && !bus.KILL) begin
            result_d = fix_res;
        end
    end

    always_comb begin
        busy  = (state_q == S_CALC) || (state_q == S_FIX);
        done  = (state_q == S_DONE);
        stall = busy || accept;
    end

    assign bus.BUSY   = busy;
    assign bus.DONE   = done;
    assign bus.STALL  = stall;
    assign bus.RESULT = result_q;
endmodule

// File: tb/tb_mdu_controller.sv
// Scoreboard bench: stimulus pushes expected result/latency, a monitor pops on DONE.
module tb_mdu_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;

    typedef struct {
        string       nm;
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;
    exp_t exp_q[$];

    mdu_controller_if #(.DATA_WIDTH(32)) bus ();

    mdu_controller #(.DATA_WIDTH(32)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.DONE) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.DONE), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.nm, "_result"}, bus.RESULT, e.res);
                    check({e.nm, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
                end
            end
        end
    end

    // Called just after a negedge; returns at the next negedge with START low.
    task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat,
                         input bit push);
        exp_t e;
        bus.START  = 1'b1;
        bus.FUNCT3 = f;
        bus.DATA1  = a;
        bus.DATA2  = b;
        if (push) begin
            e.nm = nm; e.res = res; e.lat = lat; e.t0 = cyc;
            exp_q.push_back(e);
        end
        #1;
        check({nm, "_stall_on_start"}, 32'(bus.STALL), 32'd1);
        @(negedge clk);
        bus.START  = 1'b0;
        bus.FUNCT3 = ~f;
        bus.DATA1  = 32'hDEAD_BEEF;
        bus.DATA2  = 32'h1234_5678;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
        issue(nm, f, a, b, res, lat, 1'b1);
        wait_done(60);
    endtask

    initial begin
        int bad;
        int n;
        int cnt;
        bus.START  = 1'b0;
        bus.KILL   = 1'b0;
        bus.FUNCT3 = 3'b000;
        bus.DATA1  = '0;
        bus.DATA2  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {29'd0, bus.BUSY, bus.STALL, bus.DONE}, 32'd0);
        check("reset_result", bus.RESULT, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MUL with busy/stall window check
        issue("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            if (!(bus.BUSY && bus.STALL) || bus.DONE) bad++;
            @(negedge clk);
        end
        check("mul_busy_window", 32'(bad), 32'd0);
        check("mul_busy_c34", 32'(bus.BUSY), 32'd0);
        check("mul_done_c34", 32'(bus.DONE), 32'd1);
        wait_done(10);

        run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

        // Back-to-back DIV then REM started in the DONE cycle
        issue("div_b2b", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
        n = 0;
        while (!bus.DONE && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b_reach_done", 32'(bus.DONE), 32'd1);
        issue("rem_b2b", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1);
        wait_done(60);

        run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);

        run("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run("rem_by0",  3'b110, 32'd5, 32'd0, 32'd5, 1);
        run("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run("remu_2",   3'b111, 32'd100, 32'd7, 32'd2, 34);

        // KILL in cycle 10 of a MUL
        issue("mul_kill", 3'b000, 32'd3, 32'd5, 32'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        bus.KILL = 1'b1;
        @(negedge clk);
        bus.KILL = 1'b0;
        check("kill_busy_c11", 32'(bus.BUSY), 32'd0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.DONE) cnt++;
            @(negedge clk);
        end
        check("kill_no_done", 32'(cnt), 32'd0);
        check("kill_result_held", bus.RESULT, 32'd2);
        run("mulhu_after_kill", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, 34);

        // Asynchronous reset between clock edges
        issue("mul_rst", 3'b000, 32'd9, 32'd9, 32'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_flags", {29'd0, bus.BUSY, bus.STALL, bus.DONE}, 32'd0);
        check("async_rst_result", bus.RESULT, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // START during CALC ignored
        issue("divu_ign", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        repeat (4) @(negedge clk);
        bus.START  = 1'b1;
        bus.FUNCT3 = 3'b000;
        bus.DATA1  = 32'd3;
        bus.DATA2  = 32'd3;
        @(negedge clk);
        bus.START  = 1'b0;
        wait_done(60);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.DONE) cnt++;
            @(negedge clk);
        end
        check("ignored_start_no_done", 32'(cnt), 32'd0);

        // START+KILL in IDLE: nothing starts (a div-by-zero would finish in one cycle)
        bus.START  = 1'b1;
        bus.KILL   = 1'b1;
        bus.FUNCT3 = 3'b101;
        bus.DATA1  = 32'd5;
        bus.DATA2  = 32'd0;
        #1;
        check("startkill_stall", 32'(bus.STALL), 32'd0);
        @(negedge clk);
        bus.START = 1'b0;
        bus.KILL  = 1'b0;
        check("startkill_busy", 32'(bus.BUSY), 32'd0);
        check("startkill_done", 32'(bus.DONE), 32'd0);
        check("startkill_result", bus.RESULT, 32'd14);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
